amp_enable_sequencer: RTL
=========================

Name: amp_enable_sequencer

Overview:
- Per-axis sequencer that consumes the safety-check `amp_disable` fault outputs and drives motor amplifier enables.
- Accepts host enable/disable writes and generates the registered `clear_disable` pulse that re-arms each axis's safety check.
- Waits a settle interval before asserting `amp_enable`, and latches faults for host readout.
- Sits between the host register decode and the per-axis safety-check instances on the QLA board.

Parameters:
- NUM_AXES, 4, number of axes (one safety-check instance per axis).
- CLR_CYCLES, 4, cycles `clear_disable` is held high per re-arm (1..255).
- SETTLE_CYCLES, 16, cycles waited after clear before asserting `amp_enable` (1..255).

Ports:
- clk  input  1  system clock (49.152 MHz).
- reset  input  1  asynchronous reset, active-low.
- ctrl_wen  input  1  single-cycle host write strobe.
- ctrl_mask  input  NUM_AXES  axes affected by this write; bit i=1 selects axis i.
- ctrl_en  input  NUM_AXES  requested state per selected axis; 1=enable, 0=disable.
- amp_disable  input  NUM_AXES  fault from each axis safety check; level, stays high until cleared.
- clear_disable  output  NUM_AXES  registered re-arm pulse to each safety check.
- amp_enable  output  NUM_AXES  registered amplifier enable.
- fault_latch  output  NUM_AXES  1 = axis was shut down by a fault; sticky until the next host write to that axis.
- busy  output  NUM_AXES  1 = axis is in CLEAR or SETTLE.

Behaviour:
- **Independent FSM per axis i.** States: IDLE, CLEAR, SETTLE, ON, FAULT. Each axis has one 8-bit down-counter.
- **Reset (reset=0, asynchronous).** All axes go to IDLE, counters=0, and all outputs are 0.
- **Decode.** Define wr_on = ctrl_wen & ctrl_mask[i] & ctrl_en[i] and wr_off = ctrl_wen & ctrl_mask[i] & ~ctrl_en[i]. A write with ctrl_mask=0 has no effect.
- **IDLE.**
  - wr_on -> CLEAR, counter=CLR_CYCLES-1.
  - amp_disable is ignored; fault_latch is not set in IDLE.
- **CLEAR.**
  - wr_off -> IDLE (abort).
  - counter==0 -> SETTLE, counter=SETTLE_CYCLES-1.
  - Otherwise counter decrements.
- **SETTLE.**
  - amp_disable[i]=1 -> FAULT. This is checked only after the first SETTLE cycle, because the safety check's disable clears asynchronously during CLEAR.
  - Else wr_off -> IDLE.
  - Else counter==0 -> ON.
  - Otherwise counter decrements.
- **ON.**
  - amp_disable[i]=1 -> FAULT.
  - Else wr_off -> IDLE.
  - wr_on is ignored (no re-sequence).
- **FAULT.**
  - wr_on -> CLEAR, counter=CLR_CYCLES-1, fault_latch cleared.
  - wr_off -> IDLE, fault_latch cleared.
- **Priority.** Fault beats a host write in the same cycle: ON with amp_disable=1 and wr_off goes to FAULT. wr_on while in CLEAR or SETTLE is ignored; the counter is not reloaded.
- **Outputs (registered, decoded from next state, so they change on the same edge as the state).**
  - clear_disable[i]=1 iff state==CLEAR.
  - amp_enable[i]=1 iff state==ON.
  - busy[i]=1 iff state is CLEAR or SETTLE.
  - fault_latch[i] is set on entry to FAULT and cleared only by wr_on or wr_off on axis i.
- **Latency.**
  - Write strobe sampled at edge k: clear_disable rises after edge k and stays high exactly CLR_CYCLES cycles.
  - amp_enable rises after edge k+CLR_CYCLES+SETTLE_CYCLES.
  - amp_disable sampled high at edge m in ON: amp_enable=0 and fault_latch=1 after edge m (1-cycle response).
- **Glitch freedom.** clear_disable drives an asynchronous clear downstream, so it must come directly from a flop, with no combinational decode.
- **Reset mid-sequence.** All outputs drop immediately (asynchronously); no pending sequence resumes after reset release.

Test Plan:
1. Default params, reset released, write mask=0001 en=0001 at edge 10 -> clear_disable[0]=1 for cycles 11..14, busy[0]=1 for cycles 11..30, amp_enable[0]=1 from cycle 31; axes 1-3 stay 0.
2. Axis 0 in ON, amp_disable[0] raised at edge 50 together with a wr_off to axis 0 -> after edge 50 amp_enable[0]=0, fault_latch[0]=1, state FAULT (fault wins).
3. Axis 0 in FAULT, amp_disable[0] high, write mask=0001 en=0001 -> fault_latch[0]=0, clear_disable pulse of 4 cycles.
   - If amp_disable[0] drops during CLEAR: amp_enable[0]=1 after 20 cycles total.
   - If amp_disable[0] stays high into SETTLE: FAULT again, fault_latch[0]=1.
4. Abort: enable axis 2, then write mask=0100 en=0000 during SETTLE (cycle 8 after start) -> IDLE next cycle, busy[2]=0, amp_enable[2] never asserts; a second wr_on during CLEAR does not extend the 4-cycle pulse.
5. Simultaneous multi-axis: write mask=1111 en=1010 with axes 0 and 2 in ON and axes 1 and 3 in IDLE -> axes 0 and 2 go to IDLE, axes 1 and 3 start sequencing; ctrl_wen=1 with mask=0000 changes nothing.
6. Assert reset=0 asynchronously mid-CLEAR on all axes -> clear_disable, amp_enable, busy and fault_latch all go to 0 before the next clk edge; after release all axes stay IDLE.

Source files
------------

// File: rtl/amp_enable_sequencer_if.sv
// amp_enable_sequencer_if: host-write and safety-check bundle for the amplifier enable sequencer
//   ctrl_wen      host write strobe (one cycle)
//   ctrl_mask     axes addressed by the write
//   ctrl_en       requested state per addressed axis (1=enable, 0=disable)
//   amp_disable   level fault from each axis safety check
//   clear_disable registered re-arm pulse back to each safety check
//   amp_enable    registered amplifier enable
//   fault_latch   sticky fault indication for host readout
//   busy          axis is clearing or settling
interface amp_enable_sequencer_if #(
    parameter int NUM_AXES = 4
);
    logic                ctrl_wen;
    logic [NUM_AXES-1:0] ctrl_mask;
    logic [NUM_AXES-1:0] ctrl_en;
    logic [NUM_AXES-1:0] amp_disable;
    logic [NUM_AXES-1:0] clear_disable;
    logic [NUM_AXES-1:0] amp_enable;
    logic [NUM_AXES-1:0] fault_latch;
    logic [NUM_AXES-1:0] busy;
    modport master (
        output ctrl_wen, ctrl_mask, ctrl_en, amp_disable,
        input  clear_disable, amp_enable, fault_latch, busy
    );
    modport slave (
        input  ctrl_wen, ctrl_mask, ctrl_en, amp_disable,
        output clear_disable, amp_enable, fault_latch, busy
    );
endinterface

// File: rtl/amp_enable_sequencer.sv
// amp_enable_sequencer: per-axis amplifier enable sequencing with safety-check re-arm and fault latching
//   clk    system clock
//   reset  asynchronous reset, active-low
//   bus    amp_enable_sequencer_if.slave (host writes, faults in; clear/enable/fault/busy out)
module amp_enable_sequencer #(
    parameter int NUM_AXES      = 4,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input logic                    clk,
    input logic                    reset,
    amp_enable_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ON     = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;
    localparam logic [7:0] CLR_LOAD    = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    logic [NUM_AXES-1:0] w_clear;
    logic [NUM_AXES-1:0] w_enable;
    logic [NUM_AXES-1:0] w_fault;
    logic [NUM_AXES-1:0] w_busy;
    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        logic [2:0] r_state;
        logic [2:0] w_nxt;
        logic [7:0] r_cnt;
        logic [7:0] w_cnt_nxt;
        logic       r_clear;
        logic       r_enable;
        logic       r_fault;
        logic       r_busy;
        logic       w_on;
        logic       w_off;
        logic       w_flt;
        logic       w_settle_first;
        assign w_on  = bus.ctrl_wen & bus.ctrl_mask[g] & bus.ctrl_en[g];
        assign w_off = bus.ctrl_wen & bus.ctrl_mask[g] & ~bus.ctrl_en[g];
        assign w_flt = bus.amp_disable[g];
        // The safety check's disable is still falling during the first SETTLE
        // cycle (its clear is asynchronous), so a fault is ignored there.
        assign w_settle_first = (r_cnt == SETTLE_LOAD);
        always_comb begin
            w_nxt     = r_state;
            w_cnt_nxt = r_cnt;
            case (r_state)
                S_IDLE: begin
                    w_nxt     = w_on ? S_CLEAR : S_IDLE;
                    w_cnt_nxt = w_on ? CLR_LOAD : r_cnt;
                end
                S_CLEAR: begin
                    w_nxt     = w_off ? S_IDLE : (r_cnt == 8'd0) ? S_SETTLE : S_CLEAR;
                    w_cnt_nxt = w_off ? 8'd0 : (r_cnt == 8'd0) ? SETTLE_LOAD : r_cnt - 8'd1;
                end
                S_SETTLE: begin
                    if (w_flt && !w_settle_first) begin
                        w_nxt     = S_FAULT;
                        w_cnt_nxt = 8'd0;
                    end else if (w_off) begin
                        w_nxt     = S_IDLE;
                        w_cnt_nxt = 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        w_nxt     = S_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_ON: begin
                    w_nxt = w_flt ? S_FAULT : w_off ? S_IDLE : S_ON;
                end
                S_FAULT: begin
                    w_nxt     = w_on ? S_CLEAR : w_off ? S_IDLE : S_FAULT;
                    w_cnt_nxt = w_on ? CLR_LOAD : r_cnt;
                end
                default: begin
                    w_nxt     = S_IDLE;
                    w_cnt_nxt = 8'd0;
                end
            endcase
        end
        // Outputs are decoded from the next state into flops so they move on
        // the same edge as the state and clear_disable is glitch-free.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= S_IDLE;
                r_cnt    <= 8'd0;
                r_clear  <= 1'b0;
                r_enable <= 1'b0;
                r_fault  <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                r_state  <= w_nxt;
                r_cnt    <= w_cnt_nxt;
                r_clear  <= (w_nxt == S_CLEAR);
                r_enable <= (w_nxt == S_ON);
                r_busy   <= (w_nxt == S_CLEAR) || (w_nxt == S_SETTLE);
                r_fault  <= (w_nxt == S_FAULT) ? 1'b1 : (w_on | w_off) ? 1'b0 : r_fault;
            end
        end
        assign w_clear[g]  = r_clear;
        assign w_enable[g] = r_enable;
        assign w_fault[g]  = r_fault;
        assign w_busy[g]   = r_busy;
    end
    assign bus.clear_disable = w_clear;
    assign bus.amp_enable    = w_enable;
    assign bus.fault_latch   = w_fault;
    assign bus.busy          = w_busy;
endmodule
